// File: rtl/regfile_dump_reader.sv
// Debug dump engine for the 32x32 register file. On a start pulse it walks a
// contiguous register range through a spare read port and streams each word
// as four bytes over a valid/ready byte interface, optionally preceded by a
// single frame-marker byte. It only drives the read address; it never writes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; rd_addr holds its last value
// HDR   | presenting the frame-marker byte until accepted
// LOAD  | one cycle: capture rd_data of rd_addr into the shift register
// SEND  | presenting the current byte of the captured word (4 accepts)
// DONE  | one-cycle done pulse, then back to IDLE
module regfile_dump_reader #(
  parameter int unsigned FIRST_REG   = 0,
  parameter int unsigned LAST_REG    = 31,
  parameter bit          BIG_ENDIAN  = 1'b1,
  parameter bit          HEADER_EN   = 1'b1,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic [4:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [7:0]  o_out_data,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_shift;
  logic [1:0]  r_cnt;
  logic        w_accept;
  logic        w_last_byte;

  assign o_rd_addr   = r_rd_addr;
  assign w_accept    = o_out_valid && i_out_ready;
  assign w_last_byte = (r_cnt == 2'd3);

  // State register; reset abandons any dump in flight without a done pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next state and handshake outputs; outputs depend only on state and the
  // captured word, so data stays stable while the sink stalls.
  always_comb begin
    w_next      = r_state;
    o_out_valid = 1'b0;
    o_out_data  = 8'h00;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = HEADER_EN ? ST_HDR : ST_LOAD;
      end
      ST_HDR: begin
        o_out_valid = 1'b1;
        o_out_data  = HEADER_BYTE;
        if (i_out_ready) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_next = ST_SEND;
      end
      ST_SEND: begin
        o_out_valid = 1'b1;
        o_out_data  = BIG_ENDIAN ? r_shift[31:24] : r_shift[7:0];
        if (i_out_ready && w_last_byte)
          w_next = (r_rd_addr == LAST_ADDR) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Address walk, word capture and byte shifting.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_addr <= 5'd0;
      r_shift   <= 32'h0;
      r_cnt     <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) r_rd_addr <= FIRST_ADDR;
        end
        ST_LOAD: begin
          r_shift <= i_rd_data;
          r_cnt   <= 2'd0;
        end
        ST_SEND: begin
          if (w_accept) begin
            r_shift <= BIG_ENDIAN ? {r_shift[23:0], 8'h00} : {8'h00, r_shift[31:8]};
            r_cnt   <= r_cnt + 2'd1;
            if (w_last_byte && (r_rd_addr != LAST_ADDR))
              r_rd_addr <= r_rd_addr + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
